// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/control unit.
// Contents:
//   - Instruction type codes, as seen on typeEX/typeMEM/typeWB. Code 0 is a bubble.
//   - Branch funct3 encodings, including BLTU/BGEU.
//   - The JALR opcode.
//   - The FSM state encodings HZ_RUN, HZ_LU_STALL and HZ_MEM_WAIT.
//   - Stall/flush vector index constants.
//   - Small type-classification helpers.
package pipeline_hazard_ctrl_pkg;

  localparam logic [2:0] R_TYPE = 3'd1;
  localparam logic [2:0] I_TYPE = 3'd2;
  localparam logic [2:0] S_TYPE = 3'd3;
  localparam logic [2:0] L_TYPE = 3'd4;
  localparam logic [2:0] B_TYPE = 3'd5;
  localparam logic [2:0] U_TYPE = 3'd6;
  localparam logic [2:0] J_TYPE = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] OPC_JALR = 7'b1100111;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LU_STALL = 2'd1,
    HZ_MEM_WAIT = 2'd2
  } hz_state_e;

  // Positions in the stall/flush vectors: bit0 = PC, bitk = pipeline register k
  localparam int IDX_PC    = 0;
  localparam int IDX_IFID  = 1;
  localparam int IDX_IDEX  = 2;
  localparam int IDX_EXMEM = 3;
  localparam int IDX_MEMWB = 4;

  function automatic logic is_mem_access(input logic [2:0] t);
    return (t == L_TYPE) || (t == S_TYPE);
  endfunction

  function automatic logic writes_rf(input logic [2:0] t);
    return (t == L_TYPE) || (t == R_TYPE) || (t == I_TYPE) ||
           (t == U_TYPE) || (t == J_TYPE);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_branch_resolve.sv
// Combinational branch/jump resolution for the instruction in EX.
// Ports:
//   type_ex      in   instruction type code in EX
//   funct3       in   branch condition select
//   opcode       in   full opcode; distinguishes JALR from JAL inside J_TYPE
//   zero_flag    in   ALU compare result: operands equal
//   lt_flag      in   ALU compare result: signed less-than
//   ltu_flag     in   ALU compare result: unsigned less-than
//   taken        out  a redirect is required
//   jalr_sel     out  the target comes from rs1+imm (JALR)
module pipeline_hazard_ctrl_branch_resolve
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [2:0] type_ex,
  input  logic [2:0] funct3,
  input  logic [6:0] opcode,
  input  logic       zero_flag,
  input  logic       lt_flag,
  input  logic       ltu_flag,
  output logic       taken,
  output logic       jalr_sel
);

  always_comb begin
    taken    = 1'b0;
    jalr_sel = 1'b0;
    if (type_ex == B_TYPE) begin
      // funct3 010/011 are not branch encodings and never redirect
      case (funct3)
        F3_BEQ:  taken = zero_flag;
        F3_BNE:  taken = !zero_flag;
        F3_BLT:  taken = lt_flag;
        F3_BGE:  taken = !lt_flag;
        F3_BLTU: taken = ltu_flag;
        F3_BGEU: taken = !ltu_flag;
        default: taken = 1'b0;
      endcase
    end else if (type_ex == J_TYPE) begin
      taken    = 1'b1;
      jalr_sel = (opcode == OPC_JALR);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/control unit for the 5-stage RV32I pipeline.
//
// Function:
//   - Resolves branches and jumps in EX.
//   - Inserts load-use bubbles.
//   - Holds the pipe while data memory is busy, with a watchdog that aborts
//     accesses that never complete.
//   - Drives the per-register stall/flush vectors and the RF/DMEM write strobes.
//
// Structure: outputs are combinational from the state and the inputs; the
// state, the bubble and wait counters, and the error flag are registered.
//
// Optional build macro PIPE_HAZARD_PERF_EN builds the performance counters.
// Without it, cnt_stall and cnt_flush are tied to 0.
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   typeEX, typeMEM, typeWB  instruction type codes per stage
//   funct3_EX, opcode_EX     branch condition select and opcode for EX
//   zero_flag, lt_flag, ltu_flag  ALU compare results
//   hz_load_use              ID source matches the rd of a load in EX
//   mem_busy                 DMEM not ready this cycle
//   stall[NUM_PREGS:0]       bit0 = PC, bitk = pipeline register k; 1 = hold
//   flush[NUM_PREGS:0]       bitk = 1 turns register k into a bubble on the next edge
//   pc_sel, jalr_sel         redirect the PC; take the target from rs1+imm
//   reg_we, mem_we           register-file write and data-memory write
//   load_sel                 WB mux select; 0 = load data
//   err_timeout              sticky watchdog abort flag
//   cnt_stall, cnt_flush     performance counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int NUM_PREGS   = 4,
  parameter int LU_BUBBLES  = 1,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           typeEX,
  input  logic [2:0]           typeMEM,
  input  logic [2:0]           typeWB,
  input  logic [2:0]           funct3_EX,
  input  logic [6:0]           opcode_EX,
  input  logic                 zero_flag,
  input  logic                 lt_flag,
  input  logic                 ltu_flag,
  input  logic                 hz_load_use,
  input  logic                 mem_busy,
  output logic [NUM_PREGS:0]   stall,
  output logic [NUM_PREGS:0]   flush,
  output logic                 pc_sel,
  output logic                 jalr_sel,
  output logic                 reg_we,
  output logic                 mem_we,
  output logic                 load_sel,
  output logic                 err_timeout,
  output logic [CNT_W-1:0]     cnt_stall,
  output logic [CNT_W-1:0]     cnt_flush
);

  localparam int              WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [1:0]      LU_INIT   = 2'(LU_BUBBLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_e         state, state_nxt;
  logic [1:0]        bub_cnt, bub_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              err_q, err_set;
  logic              br_taken, br_jalr;
  logic              run_rules;
  logic [NUM_PREGS:0] stall_c, flush_c;
  logic              pc_sel_c, jalr_c;

  pipeline_hazard_ctrl_branch_resolve u_branch (
    .type_ex   (typeEX),
    .funct3    (funct3_EX),
    .opcode    (opcode_EX),
    .zero_flag (zero_flag),
    .lt_flag   (lt_flag),
    .ltu_flag  (ltu_flag),
    .taken     (br_taken),
    .jalr_sel  (br_jalr)
  );

  always_comb begin
    stall_c   = '0;
    flush_c   = '0;
    pc_sel_c  = 1'b0;
    jalr_c    = 1'b0;
    state_nxt = state;
    bub_nxt   = bub_cnt;
    wait_nxt  = wait_cnt;
    err_set   = 1'b0;
    run_rules = 1'b0;

    if (state == HZ_MEM_WAIT) begin
      if (mem_busy) begin
        // EX is frozen, so any redirect waits until memory completes
        stall_c[IDX_EXMEM:IDX_PC] = '1;
        flush_c[IDX_MEMWB]        = 1'b1;
        if (wait_cnt == WAIT_LAST) begin
          // Watchdog: drop the stuck access and resume
          flush_c[IDX_EXMEM] = 1'b1;
          err_set            = 1'b1;
          state_nxt          = HZ_RUN;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end else begin
        run_rules = 1'b1;
      end
    end else begin
      run_rules = 1'b1;
    end

    if (run_rules) begin
      if (mem_busy && is_mem_access(typeMEM)) begin
        stall_c[IDX_EXMEM:IDX_PC] = '1;
        flush_c[IDX_MEMWB]        = 1'b1;
        state_nxt                 = HZ_MEM_WAIT;
        // The entry cycle is the first cycle of the wait
        wait_nxt                  = WAIT_W'(1);
      end else if (br_taken) begin
        // A coincident load-use victim sits in ID and is flushed anyway
        pc_sel_c           = 1'b1;
        jalr_c             = br_jalr;
        flush_c[IDX_IFID]  = 1'b1;
        flush_c[IDX_IDEX]  = 1'b1;
        state_nxt          = HZ_RUN;
      end else if (state == HZ_LU_STALL) begin
        stall_c[IDX_IFID:IDX_PC] = '1;
        flush_c[IDX_IDEX]        = 1'b1;
        bub_nxt                  = bub_cnt - 2'd1;
        if (bub_cnt <= 2'd1) state_nxt = HZ_RUN;
      end else if (hz_load_use) begin
        stall_c[IDX_IFID:IDX_PC] = '1;
        flush_c[IDX_IDEX]        = 1'b1;
        bub_nxt                  = LU_INIT;
        state_nxt                = (LU_INIT != 2'd0) ? HZ_LU_STALL : HZ_RUN;
      end else begin
        state_nxt = HZ_RUN;
      end
    end

    if (reset) begin
      stall_c   = '0;
      flush_c   = '1;
      pc_sel_c  = 1'b0;
      jalr_c    = 1'b0;
      err_set   = 1'b0;
      state_nxt = HZ_RUN;
    end
  end

  assign stall       = stall_c;
  assign flush       = flush_c;
  assign pc_sel      = pc_sel_c;
  assign jalr_sel    = jalr_c;
  assign reg_we      = !reset && writes_rf(typeWB);
  assign mem_we      = !reset && (typeMEM == S_TYPE) && !flush_c[IDX_EXMEM];
  assign load_sel    = reset || (typeMEM != L_TYPE);
  assign err_timeout = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HZ_RUN;
      bub_cnt  <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      bub_cnt  <= bub_nxt;
      wait_cnt <= wait_nxt;
      err_q    <= err_q | err_set;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] cnt_stall_q, cnt_flush_q;

  // Both counters wrap naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_stall_q <= '0;
      cnt_flush_q <= '0;
    end else begin
      if (stall_c[IDX_PC]) cnt_stall_q <= cnt_stall_q + CNT_W'(1);
      if (pc_sel_c)        cnt_flush_q <= cnt_flush_q + CNT_W'(1);
    end
  end

  assign cnt_stall = cnt_stall_q;
  assign cnt_flush = cnt_flush_q;
`else
  assign cnt_stall = '0;
  assign cnt_flush = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int NP = 4;
  localparam logic [2:0] T_NOP = 3'd0, T_R = 3'd1, T_S = 3'd3, T_L = 3'd4,
                         T_B = 3'd5, T_U = 3'd6, T_J = 3'd7;
  localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    typeEX, typeMEM, typeWB, funct3_EX;
  logic [6:0]    opcode_EX;
  logic          zero_flag, lt_flag, ltu_flag, hz_load_use, mem_busy;
  logic [NP:0]   stall, flush;
  logic          pc_sel, jalr_sel, reg_we, mem_we, load_sel, err_timeout;
  logic [31:0]   cnt_stall, cnt_flush;

  int n_vec = 0;
  int n_err = 0;

  pipeline_hazard_ctrl #(
    .NUM_PREGS(NP), .LU_BUBBLES(2), .MEM_TIMEOUT(4), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .typeEX(typeEX), .typeMEM(typeMEM), .typeWB(typeWB),
    .funct3_EX(funct3_EX), .opcode_EX(opcode_EX), .zero_flag(zero_flag),
    .lt_flag(lt_flag), .ltu_flag(ltu_flag), .hz_load_use(hz_load_use),
    .mem_busy(mem_busy), .stall(stall), .flush(flush), .pc_sel(pc_sel),
    .jalr_sel(jalr_sel), .reg_we(reg_we), .mem_we(mem_we), .load_sel(load_sel),
    .err_timeout(err_timeout), .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
  );

  always #5 clk = ~clk;

  task automatic idle();
    typeEX = T_NOP; typeMEM = T_NOP; typeWB = T_NOP; funct3_EX = 3'b000;
    opcode_EX = 7'd0; zero_flag = 1'b0; lt_flag = 1'b0; ltu_flag = 1'b0;
    hz_load_use = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; idle(); typeWB = T_R; typeMEM = T_L;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_vec++; if (flush !== 5'b11111) begin n_err++; $display("FAIL reset_flush c%0d got=%b exp=11111", c, flush); end
      n_vec++; if (stall !== 5'b00000) begin n_err++; $display("FAIL reset_stall c%0d got=%b exp=00000", c, stall); end
      n_vec++; if (load_sel !== 1'b1 || reg_we !== 1'b0 || pc_sel !== 1'b0)
        begin n_err++; $display("FAIL reset_ctl c%0d got ls=%b we=%b pc=%b exp 1 0 0", c, load_sel, reg_we, pc_sel); end
      @(negedge clk);
    end
    reset = 1'b0; idle(); #1;
    n_vec++; if (flush !== 5'b00000 || stall !== 5'b00000)
      begin n_err++; $display("FAIL release got flush=%b stall=%b exp 00000 00000", flush, stall); end
    n_vec++; if (err_timeout !== 1'b0 || cnt_stall !== 32'd0 || cnt_flush !== 32'd0)
      begin n_err++; $display("FAIL release_regs got err=%b cs=%0d cf=%0d exp 0 0 0", err_timeout, cnt_stall, cnt_flush); end
  endtask

  task automatic test_branch();
    // {funct3, zero, lt, ltu, expected taken}
    logic [6:0] vec [7] = '{
      {3'b110, 1'b0, 1'b0, 1'b1, 1'b1},
      {3'b111, 1'b0, 1'b0, 1'b1, 1'b0},
      {3'b000, 1'b1, 1'b0, 1'b0, 1'b1},
      {3'b001, 1'b1, 1'b0, 1'b0, 1'b0},
      {3'b100, 1'b0, 1'b1, 1'b0, 1'b1},
      {3'b101, 1'b0, 1'b0, 1'b0, 1'b1},
      {3'b010, 1'b1, 1'b1, 1'b1, 1'b0}};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      idle(); typeEX = T_B;
      {funct3_EX, zero_flag, lt_flag, ltu_flag} = vec[i][6:1];
      #1;
      n_vec++; if (pc_sel !== vec[i][0] || jalr_sel !== 1'b0)
        begin n_err++; $display("FAIL branch%0d pc_sel got=%b jalr=%b exp=%b 0", i, pc_sel, jalr_sel, vec[i][0]); end
      n_vec++; if (flush !== (vec[i][0] ? 5'b00110 : 5'b00000) || stall !== 5'b00000)
        begin n_err++; $display("FAIL branch%0d flush got=%b stall=%b exp taken=%b", i, flush, stall, vec[i][0]); end
    end
  endtask

  task automatic test_jump();
    @(negedge clk); idle(); typeEX = T_J; opcode_EX = OP_JAL; #1;
    n_vec++; if (pc_sel !== 1'b1 || jalr_sel !== 1'b0 || flush !== 5'b00110)
      begin n_err++; $display("FAIL jal got pc=%b jalr=%b flush=%b exp 1 0 00110", pc_sel, jalr_sel, flush); end
    @(negedge clk); opcode_EX = OP_JALR; #1;
    n_vec++; if (pc_sel !== 1'b1 || jalr_sel !== 1'b1)
      begin n_err++; $display("FAIL jalr got pc=%b jalr=%b exp 1 1", pc_sel, jalr_sel); end
  endtask

  task automatic test_load_use();
    @(negedge clk); idle(); hz_load_use = 1'b1; #1;
    n_vec++; if (stall !== 5'b00011 || flush !== 5'b00100)
      begin n_err++; $display("FAIL lu_cyc1 got stall=%b flush=%b exp 00011 00100", stall, flush); end
    @(negedge clk); hz_load_use = 1'b0; #1;
    n_vec++; if (stall !== 5'b00011 || flush !== 5'b00100)
      begin n_err++; $display("FAIL lu_cyc2 got stall=%b flush=%b exp 00011 00100", stall, flush); end
    @(negedge clk); #1;
    n_vec++; if (stall !== 5'b00000 || flush !== 5'b00000)
      begin n_err++; $display("FAIL lu_done got stall=%b flush=%b exp 00000 00000", stall, flush); end
  endtask

  task automatic test_mem_wait();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); idle(); typeMEM = T_L; mem_busy = 1'b1; typeEX = T_J; opcode_EX = OP_JAL; #1;
      n_vec++; if (stall !== 5'b01111 || flush !== 5'b10000 || pc_sel !== 1'b0)
        begin n_err++; $display("FAIL memwait c%0d got stall=%b flush=%b pc=%b exp 01111 10000 0", c, stall, flush, pc_sel); end
      n_vec++; if (load_sel !== 1'b0)
        begin n_err++; $display("FAIL memwait_ls c%0d got=%b exp=0", c, load_sel); end
    end
    @(negedge clk); mem_busy = 1'b0; #1;
    n_vec++; if (pc_sel !== 1'b1 || stall !== 5'b00000 || flush !== 5'b00110)
      begin n_err++; $display("FAIL memwait_redirect got pc=%b stall=%b flush=%b exp 1 00000 00110", pc_sel, stall, flush); end
    n_vec++; if (err_timeout !== 1'b0)
      begin n_err++; $display("FAIL memwait_err got=%b exp=0", err_timeout); end
  endtask

  task automatic test_write_enables();
    logic [2:0] wb [4] = '{T_R, T_S, T_B, T_U};
    logic       we [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle(); typeWB = wb[i]; typeMEM = (i[0]) ? T_S : T_L; #1;
      n_vec++; if (reg_we !== we[i])
        begin n_err++; $display("FAIL reg_we%0d got=%b exp=%b", i, reg_we, we[i]); end
      n_vec++; if (mem_we !== i[0] || load_sel !== i[0])
        begin n_err++; $display("FAIL memsel%0d got we=%b ls=%b exp %b %b", i, mem_we, load_sel, i[0], i[0]); end
    end
  endtask

  task automatic test_timeout();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); idle(); typeMEM = T_S; mem_busy = 1'b1; #1;
      n_vec++; if (flush !== 5'b10000 || stall !== 5'b01111 || mem_we !== 1'b1)
        begin n_err++; $display("FAIL to_wait c%0d got flush=%b stall=%b mwe=%b exp 10000 01111 1", c, flush, stall, mem_we); end
    end
    @(negedge clk); #1;
    n_vec++; if (flush !== 5'b11000 || mem_we !== 1'b0)
      begin n_err++; $display("FAIL to_abort got flush=%b mwe=%b exp 11000 0", flush, mem_we); end
    @(negedge clk); idle(); #1;
    n_vec++; if (err_timeout !== 1'b1 || stall !== 5'b00000)
      begin n_err++; $display("FAIL to_err got err=%b stall=%b exp 1 00000", err_timeout, stall); end
    @(negedge clk); #1;
    n_vec++; if (err_timeout !== 1'b1)
      begin n_err++; $display("FAIL to_sticky got=%b exp=1", err_timeout); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); idle(); reset = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    n_vec++; if (err_timeout !== 1'b0)
      begin n_err++; $display("FAIL b2b_errclr got=%b exp=0", err_timeout); end
    @(negedge clk); typeEX = T_B; funct3_EX = 3'b000; zero_flag = 1'b1; hz_load_use = 1'b1; #1;
    n_vec++; if (pc_sel !== 1'b1 || stall !== 5'b00000 || flush !== 5'b00110)
      begin n_err++; $display("FAIL b2b got pc=%b stall=%b flush=%b exp 1 00000 00110", pc_sel, stall, flush); end
    @(negedge clk); idle(); #1;
    n_vec++; if (stall !== 5'b00000)
      begin n_err++; $display("FAIL b2b_nolu got stall=%b exp=00000", stall); end
`ifdef PIPE_HAZARD_PERF_EN
    n_vec++; if (cnt_flush !== 32'd1 || cnt_stall !== 32'd0)
      begin n_err++; $display("FAIL b2b_cnt got cf=%0d cs=%0d exp 1 0", cnt_flush, cnt_stall); end
`else
    n_vec++; if (cnt_flush !== 32'd0 || cnt_stall !== 32'd0)
      begin n_err++; $display("FAIL b2b_cnt got cf=%0d cs=%0d exp 0 0", cnt_flush, cnt_stall); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_branch();
    test_jump();
    test_load_use();
    test_mem_wait();
    test_write_enables();
    test_timeout();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
